// File: rtl/popcount_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : popcount_window_stats
// Description : Counts 1-bits per accepted word and emits per-window totals,
//               maximum per-word count and all-zero word count.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_window_stats #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int SUM_W = $clog2(WIDTH * WINDOW + 1),
  localparam int WC_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_max,
  output logic [WC_W-1:0]  out_zero_cnt
);

  localparam logic [WC_W-1:0] c_last_wc = WC_W'(WINDOW - 1);

  logic [WC_W-1:0]  r_wc;
  logic [SUM_W-1:0] r_acc_sum;
  logic [CNT_W-1:0] r_acc_max;
  logic [WC_W-1:0]  r_acc_zero;
  logic             r_out_valid;
  logic [SUM_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_max;
  logic [WC_W-1:0]  r_out_zero;

  logic [CNT_W-1:0] w_pc;
  logic             w_is_zero;
  logic             w_accept;
  logic             w_emit;
  logic             w_final;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_max;
  logic [WC_W-1:0]  w_zero;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pc = w_pc + CNT_W'(in_data[i]);
    end
  end

  assign w_is_zero = (in_data == '0);
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = r_out_valid && out_ready;
  assign w_final   = (r_wc == c_last_wc);

  // Accumulators combined with the word on the input this cycle.
  assign w_sum  = r_acc_sum + SUM_W'(w_pc);
  assign w_max  = (w_pc > r_acc_max) ? w_pc : r_acc_max;
  assign w_zero = r_acc_zero + WC_W'(w_is_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wc        <= '0;
      r_acc_sum   <= '0;
      r_acc_max   <= '0;
      r_acc_zero  <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_zero  <= '0;
    end else begin
      if (w_accept) begin
        if (w_final) begin
          r_out_sum  <= w_sum;
          r_out_max  <= w_max;
          r_out_zero <= w_zero;
          r_wc       <= '0;
          r_acc_sum  <= '0;
          r_acc_max  <= '0;
          r_acc_zero <= '0;
        end else begin
          r_wc       <= r_wc + WC_W'(1);
          r_acc_sum  <= w_sum;
          r_acc_max  <= w_max;
          r_acc_zero <= w_zero;
        end
      end
      // A window completing on the emit edge keeps the record stream valid.
      if (w_accept && w_final) begin
        r_out_valid <= 1'b1;
      end else if (w_emit) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_max      = r_out_max;
  assign out_zero_cnt = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_popcount_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_window_stats
// Description : Directed self-checking bench over WINDOW = 4, 8 and 1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_window_stats;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  // WINDOW = 4 instance
  logic       a_valid = 1'b0, a_ready, a_ovalid, a_oready = 1'b1;
  logic [3:0] a_data = '0;
  logic [4:0] a_sum;
  logic [2:0] a_max;
  logic [2:0] a_zc;

  // WINDOW = 8 instance
  logic       b_valid = 1'b0, b_ready, b_ovalid, b_oready = 1'b1;
  logic [3:0] b_data = '0;
  logic [5:0] b_sum;
  logic [2:0] b_max;
  logic [3:0] b_zc;

  // WINDOW = 1 instance
  logic       c_valid = 1'b0, c_ready, c_ovalid, c_oready = 1'b1;
  logic [3:0] c_data = '0;
  logic [2:0] c_sum;
  logic [2:0] c_max;
  logic [0:0] c_zc;

  popcount_window_stats #(.WIDTH(4), .WINDOW(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_sum(a_sum), .out_max(a_max),
    .out_zero_cnt(a_zc)
  );

  popcount_window_stats #(.WIDTH(4), .WINDOW(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_sum(b_sum), .out_max(b_max),
    .out_zero_cnt(b_zc)
  );

  popcount_window_stats #(.WIDTH(4), .WINDOW(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .out_valid(c_ovalid), .out_ready(c_oready), .out_sum(c_sum), .out_max(c_max),
    .out_zero_cnt(c_zc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_rec(input string tag, input int s, input int m, input int z);
    chk({tag, " a_valid"}, a_ovalid, 1);
    chk({tag, " a_sum"}, a_sum, s);
    chk({tag, " a_max"}, a_max, m);
    chk({tag, " a_zero"}, a_zc, z);
  endtask

  task automatic a_feed(input logic [3:0] d);
    a_valid = 1'b1;
    a_data  = d;
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst a_valid", a_ovalid, 0);
    chk("rst a_sum", a_sum, 0);
    chk("rst a_max", a_max, 0);
    chk("rst a_zero", a_zc, 0);
    chk("rst a_ready", a_ready, 1);
    chk("rst b_valid", b_ovalid, 0);
    chk("rst c_valid", c_ovalid, 0);
    chk("rst c_ready", c_ready, 1);
    rst = 1'b0;
    step();

    // Basic window: 1 + 2 + 4 + 2 = 9, max 4
    a_feed(4'b0001);
    a_feed(4'b0110);
    a_feed(4'b1111);
    chk("mid a_valid", a_ovalid, 0);
    a_feed(4'b1100);
    a_rec("basic", 9, 4, 0);
    a_valid = 1'b0;
    step();
    chk("basic emit a_valid", a_ovalid, 0);
    chk("basic hold a_sum", a_sum, 9);

    // All-zero window
    repeat (4) a_feed(4'b0000);
    a_rec("zeros", 0, 0, 4);
    a_valid = 1'b0;
    step();
    chk("zeros emit", a_ovalid, 0);

    // Backpressure: 1010,1000,0000,0111 -> sum 6, max 3, one zero word
    a_oready = 1'b0;
    a_feed(4'b1010);
    a_feed(4'b1000);
    a_feed(4'b0000);
    a_feed(4'b0111);
    a_rec("bp", 6, 3, 1);
    a_data = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      chk("bp a_ready", a_ready, 0);
      step();
      a_rec("bp stable", 6, 3, 1);
    end
    a_oready = 1'b1;
    #1;
    chk("bp release a_ready", a_ready, 1);
    step();
    chk("bp emit a_valid", a_ovalid, 0);
    repeat (3) a_feed(4'b1111);
    a_rec("bp next", 16, 4, 0);
    a_valid = 1'b0;
    step();
    chk("bp next emit", a_ovalid, 0);

    // Reset mid-window discards the partial window
    a_feed(4'b1111);
    a_feed(4'b1111);
    a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst a_valid", a_ovalid, 0);
    chk("midrst a_ready", a_ready, 1);
    step();
    rst = 1'b0;
    a_feed(4'b0001);
    a_feed(4'b0001);
    chk("midrst no early rec", a_ovalid, 0);
    a_feed(4'b0001);
    a_feed(4'b0001);
    a_rec("midrst", 4, 1, 0);
    a_valid = 1'b0;
    step();

    // WINDOW = 8 streaming, no bubbles
    b_valid = 1'b1;
    b_data  = 4'b1111;
    for (int n = 1; n <= 24; n++) begin
      step();
      chk("w8 b_ready", b_ready, 1);
      chk("w8 b_valid", b_ovalid, ((n % 8) == 0) ? 1 : 0);
      if ((n % 8) == 0) begin
        chk("w8 b_sum", b_sum, 32);
        chk("w8 b_max", b_max, 4);
        chk("w8 b_zero", b_zc, 0);
      end
    end
    b_valid = 1'b0;
    step();
    chk("w8 tail b_valid", b_ovalid, 0);

    // WINDOW = 1: one record per word, back to back
    c_valid = 1'b1;
    c_data  = 4'b0011;
    step();
    chk("w1 r0 valid", c_ovalid, 1);
    chk("w1 r0 sum", c_sum, 2);
    chk("w1 r0 max", c_max, 2);
    c_data = 4'b0000;
    step();
    chk("w1 r1 valid", c_ovalid, 1);
    chk("w1 r1 sum", c_sum, 0);
    chk("w1 r1 zero", c_zc, 1);
    c_data = 4'b0111;
    step();
    chk("w1 r2 valid", c_ovalid, 1);
    chk("w1 r2 sum", c_sum, 3);
    chk("w1 r2 max", c_max, 3);
    chk("w1 r2 zero", c_zc, 0);
    c_valid = 1'b0;
    step();
    chk("w1 end valid", c_ovalid, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/popcount_window_stats.md
# popcount_window_stats

Streaming stage that consumes WIDTH-bit sample words and counts the 1-bits in each one. It accumulates per-window statistics over WINDOW accepted words: total ones, maximum per-word ones, and the number of all-zero words. It emits one result record per window over a valid/ready handshake. It sits downstream of the sample driver and feeds the monitor/scoreboard that reports bit-population statistics.

## Interface
- WIDTH, 4, bits per input word (≥1)
- WINDOW, 8, accepted words per result record (≥1)
- Derived localparams:
  - CNT_W = $clog2(WIDTH+1)
  - SUM_W = $clog2(WIDTH*WINDOW+1)
  - WC_W = $clog2(WINDOW+1)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  WIDTH  sample word
- out_valid  out  1  result record present
- out_ready  in  1  consumer accepts record
- out_sum  out  SUM_W  total 1-bits over the window
- out_max  out  CNT_W  largest per-word 1-count in the window
- out_zero_cnt  out  WC_W  number of words equal to 0 in the window

## Operation
- Accept: in_valid && in_ready at posedge. Emit: out_valid && out_ready at posedge.
- in_ready = !out_valid || out_ready (combinational). A pending record is never overwritten.
- Per accepted word: pc = number of 1-bits in in_data. pc is combinational and zero-extended to SUM_W.
- Internal state:
  - word counter wc (0..WINDOW-1)
  - accumulators acc_sum, acc_max, acc_zero
  - output registers
- Two implicit phases: ACCUM (out_valid=0) and HOLD (out_valid=1). HOLD→ACCUM on emit, unless a new window completes in the same cycle.
- Non-final accept (wc < WINDOW-1):
  - acc_sum += pc
  - acc_max = max(acc_max, pc)
  - acc_zero += (in_data==0)
  - wc += 1
- Final accept (wc == WINDOW-1):
  - out_sum/out_max/out_zero_cnt ← accumulators combined with the current word
  - out_valid ← 1
  - accumulators and wc cleared to 0
- Emit without final accept: out_valid ← 0; output data holds its last value.
- Emit and final accept in the same cycle: out_valid stays 1 and output data updates to the new record. Only reachable when out_ready=1.
- WINDOW=1: every accepted word produces a record.
- Arithmetic never overflows: SUM_W and WC_W are sized for the worst case. No saturation logic.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the environment):
  - out_valid=0, out_sum=0, out_max=0, out_zero_cnt=0
  - wc=0, all accumulators 0
  - in_ready=1
- Reset mid-window discards the partial window. No record is emitted for it.
- Latency: record valid on the cycle after the final word's accept edge (1 cycle).
- Throughput: 1 word/cycle sustained while out_ready=1. No bubble between windows.
- Backpressure:
  - out_valid=1 and out_ready=0 → in_ready=0.
  - out_sum/out_max/out_zero_cnt/out_valid stay stable until emit.
- in_data is ignored when in_valid=0 or in_ready=0.

## Test plan
- WIDTH=4, WINDOW=4, out_ready=1:
  - feed 0001, 0110, 1111, 1100
  - → one cycle after 4th accept: out_valid=1, out_sum=9, out_max=4, out_zero_cnt=0
- WINDOW=4: feed 0000 ×4 → out_sum=0, out_max=0, out_zero_cnt=4.
- Backpressure, out_ready=0 after the first record completes:
  - in_ready=0 and outputs stable for 5 cycles
  - raise out_ready → emit on that edge, in_ready=1 the same cycle
  - next window unaffected
- Reset mid-window:
  - accept 1111, 1111, assert rst for 1 cycle
  - then feed 0001 ×4 → out_sum=4, out_max=1, out_zero_cnt=0
- WINDOW=8, in_valid=1 continuously, data 1111, out_ready=1:
  - records every 8 cycles with out_sum=32, out_max=4
  - out_valid high exactly 1 cycle each; in_ready never drops
- WINDOW=1, out_ready=1:
  - stream 0011, 0000, 0111 → three consecutive records with out_sum 2, 0, 3
  - out_valid high 3 cycles back-to-back
